// File: rtl/pwm_cfg_pkg.sv
// Shared register map and scheduler state encoding for the PWM configuration path.
// The SPI peripheral imports the same address constants.
package pwm_cfg_pkg;

    localparam int unsigned ADDR_OUT_LO  = 32'h00;
    localparam int unsigned ADDR_OUT_HI  = 32'h01;
    localparam int unsigned ADDR_PWM_LO  = 32'h02;
    localparam int unsigned ADDR_PWM_HI  = 32'h03;
    localparam int unsigned ADDR_DUTY    = 32'h04;
    localparam int unsigned ADDR_MAX     = 32'h04;

    localparam int unsigned NUM_IMMEDIATE = 2;
    localparam int unsigned NUM_DEFERRED  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_cfg_shadow_bank.sv
// Shadow and active copies of the deferred PWM registers (PWM enable lo/hi, duty).
// Shadows take writes at any time; actives load from shadows only on the commit strobe.
module pwm_cfg_shadow_bank
    import pwm_cfg_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [1:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    output logic [DATA_W-1:0] pwm_lo,
    output logic [DATA_W-1:0] pwm_hi,
    output logic [DATA_W-1:0] duty
);

    logic [DATA_W-1:0] shadow_q [NUM_DEFERRED];
    logic [DATA_W-1:0] active_q [NUM_DEFERRED];

    generate
        for (genvar gi = 0; gi < NUM_DEFERRED; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q[gi] <= '0;
                end else if (wr_en && wr_idx == 2'(gi)) begin
                    shadow_q[gi] <= wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    active_q[gi] <= '0;
                end else if (commit) begin
                    active_q[gi] <= shadow_q[gi];
                end
            end
        end
    endgenerate

    assign pwm_lo = active_q[0];
    assign pwm_hi = active_q[1];
    assign duty   = active_q[2];

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// PWM configuration register owner: output-enable writes apply immediately, PWM-enable and
// duty writes are shadowed and committed together at a period boundary or on timeout.
module pwm_cfg_scheduler
    import pwm_cfg_pkg::*;
#(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4096,
    parameter int CNT_W    = $clog2(MAX_WAIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              period_end,
    input  logic              force_commit,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              pending,
    output logic              commit_pulse,
    output logic              addr_err
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] imm_q [NUM_IMMEDIATE];
    logic              commit_pulse_q;
    logic              addr_err_q;

    logic wr_fire;
    logic deferred_hit;
    logic invalid_hit;
    logic trigger;
    logic commit_strobe;

    assign wr_ready      = (state_q != ST_COMMIT);
    assign wr_fire       = wr_valid && wr_ready;
    assign deferred_hit  = wr_fire && (wr_addr >= ADDR_W'(ADDR_PWM_LO))
                                   && (wr_addr <= ADDR_W'(ADDR_DUTY));
    assign invalid_hit   = wr_fire && (wr_addr > ADDR_W'(ADDR_MAX));
    assign trigger       = period_end || force_commit || (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
    assign commit_strobe = (state_q == ST_COMMIT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (deferred_hit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (trigger) begin
                    state_d = ST_COMMIT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= '0;
            commit_pulse_q <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            commit_pulse_q <= commit_strobe;
            if (invalid_hit) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IMMEDIATE; gi++) begin : g_imm
            always_ff @(posedge clk) begin
                if (rst) begin
                    imm_q[gi] <= '0;
                end else if (wr_fire && wr_addr == ADDR_W'(ADDR_OUT_LO + gi)) begin
                    imm_q[gi] <= wr_data;
                end
            end
        end
    endgenerate

    // Addresses 2,3,4 have low bits 10,11,00; subtracting 2 mod 4 yields slot 0,1,2.
    pwm_cfg_shadow_bank #(
        .DATA_W (DATA_W)
    ) u_shadow_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (deferred_hit),
        .wr_idx  (wr_addr[1:0] - 2'd2),
        .wr_data (wr_data),
        .commit  (commit_strobe),
        .pwm_lo  (en_reg_pwm_7_0),
        .pwm_hi  (en_reg_pwm_15_8),
        .duty    (pwm_duty_cycle)
    );

    assign en_reg_out_7_0  = imm_q[0];
    assign en_reg_out_15_8 = imm_q[1];
    assign pending         = (state_q != ST_IDLE);
    assign commit_pulse    = commit_pulse_q;
    assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Bench for pwm_cfg_scheduler: directed scenarios plus randomized traffic against a
// timestamp-based reference model; a second instance with a short timeout covers forced commits.
module tb_pwm_cfg_scheduler;

    localparam int MAX_WAIT_A = 4096;
    localparam int MAX_WAIT_B = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       period_end = 1'b0;
    logic       force_commit = 1'b0;
    logic       wr_ready;
    logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
    logic       pending, commit_pulse, addr_err;

    logic       rst_b = 1'b1;
    logic       wr_valid_b = 1'b0;
    logic [6:0] wr_addr_b = '0;
    logic [7:0] wr_data_b = '0;
    logic       wr_ready_b;
    logic [7:0] out_lo_b, out_hi_b, pwm_lo_b, pwm_hi_b, duty_b;
    logic       pending_b, commit_pulse_b, addr_err_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_cfg_scheduler #(.MAX_WAIT(MAX_WAIT_A)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .period_end(period_end),
        .force_commit(force_commit), .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
        .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi), .pwm_duty_cycle(duty),
        .pending(pending), .commit_pulse(commit_pulse), .addr_err(addr_err)
    );

    pwm_cfg_scheduler #(.MAX_WAIT(MAX_WAIT_B)) dut_b (
        .clk(clk), .rst(rst_b), .wr_valid(wr_valid_b), .wr_ready(wr_ready_b),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .period_end(1'b0),
        .force_commit(1'b0), .en_reg_out_7_0(out_lo_b), .en_reg_out_15_8(out_hi_b),
        .en_reg_pwm_7_0(pwm_lo_b), .en_reg_pwm_15_8(pwm_hi_b), .pwm_duty_cycle(duty_b),
        .pending(pending_b), .commit_pulse(commit_pulse_b), .addr_err(addr_err_b)
    );

    // Reference model: register file plus "pending since edge" and "commit due after edge" stamps.
    logic [7:0] m_act [5];
    logic [7:0] m_shd [3];
    bit         m_pend;
    int         m_start;
    int         m_trig = -1;
    bit         m_pulse;
    bit         m_err;
    int         cyc = 0;

    task automatic model_edge();
        bit was_pend;
        int a;
        cyc++;
        if (rst) begin
            foreach (m_act[i]) m_act[i] = 8'h00;
            foreach (m_shd[i]) m_shd[i] = 8'h00;
            m_pend  = 0;
            m_trig  = -1;
            m_pulse = 0;
            m_err   = 0;
        end else if (m_trig >= 0) begin
            for (int i = 0; i < 3; i++) m_act[i + 2] = m_shd[i];
            m_pend  = 0;
            m_trig  = -1;
            m_pulse = 1;
        end else begin
            was_pend = m_pend;
            a = int'(wr_addr);
            m_pulse = 0;
            if (wr_valid) begin
                if (a <= 1) begin
                    m_act[a] = wr_data;
                end else if (a <= 4) begin
                    m_shd[a - 2] = wr_data;
                    if (!m_pend) begin
                        m_pend  = 1;
                        m_start = cyc;
                    end
                end else begin
                    m_err = 1;
                end
            end
            if (was_pend && (period_end || force_commit || (cyc - m_start) == MAX_WAIT_A))
                m_trig = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        $display("txn write addr=0x%02h data=0x%02h t=%0t", a, d, $time);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'h0) begin
            failures++;
            $display("FAIL reset_regs got=%h exp=0", {out_lo, out_hi, pwm_lo, pwm_hi, duty});
        end
        checks++;
        if ({pending, commit_pulse, addr_err, wr_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0001", {pending, commit_pulse, addr_err, wr_ready});
        end
    endtask

    task automatic test_immediate();
        do_write(7'h00, 8'hA5);
        checks++;
        if (out_lo !== 8'hA5) begin
            failures++;
            $display("FAIL imm_out_lo got=%h exp=a5", out_lo);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pending !== 1'b0 || commit_pulse !== 1'b0) begin
                failures++;
                $display("FAIL imm_no_pending cyc=%0d pending=%b pulse=%b exp=0/0", i, pending, commit_pulse);
            end
            tick();
        end
    endtask

    task automatic test_period_commit();
        do_write(7'h04, 8'h80);
        for (int i = 0; i < 9; i++) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        checks++;
        if (duty !== 8'h00 || wr_ready !== 1'b0 || pending !== 1'b1) begin
            failures++;
            $display("FAIL period_trigger duty=%h ready=%b pending=%b exp=00/0/1", duty, wr_ready, pending);
        end
        tick();
        checks++;
        if (duty !== 8'h80 || commit_pulse !== 1'b1 || wr_ready !== 1'b1 || pending !== 1'b0) begin
            failures++;
            $display("FAIL period_commit duty=%h pulse=%b ready=%b pending=%b exp=80/1/1/0",
                     duty, commit_pulse, wr_ready, pending);
        end
        tick();
        checks++;
        if (commit_pulse !== 1'b0) begin
            failures++;
            $display("FAIL period_pulse_width pulse=%b exp=0", commit_pulse);
        end
    endtask

    task automatic test_back_to_back();
        do_write(7'h02, 8'h0F);
        period_end = 1'b1;
        do_write(7'h03, 8'hF0);
        period_end = 1'b0;
        checks++;
        if (pwm_lo !== 8'h00 || pwm_hi !== 8'h00) begin
            failures++;
            $display("FAIL b2b_early lo=%h hi=%h exp=00/00", pwm_lo, pwm_hi);
        end
        tick();
        checks++;
        if (pwm_lo !== 8'h0F || pwm_hi !== 8'hF0 || commit_pulse !== 1'b1) begin
            failures++;
            $display("FAIL b2b_commit lo=%h hi=%h pulse=%b exp=0f/f0/1", pwm_lo, pwm_hi, commit_pulse);
        end
        tick();
    endtask

    task automatic test_addr_err();
        do_write(7'h05, 8'hFF);
        checks++;
        if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'hA5_00_0F_F0_80 || addr_err !== 1'b1
            || pending !== 1'b0) begin
            failures++;
            $display("FAIL addr_err_set regs=%h err=%b pending=%b exp=a5000ff080/1/0",
                     {out_lo, out_hi, pwm_lo, pwm_hi, duty}, addr_err, pending);
        end
        do_write(7'h01, 8'h3C);
        checks++;
        if (out_hi !== 8'h3C || addr_err !== 1'b1) begin
            failures++;
            $display("FAIL addr_err_sticky out_hi=%h err=%b exp=3c/1", out_hi, addr_err);
        end
    endtask

    task automatic test_reset_pending();
        do_write(7'h04, 8'h33);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({out_lo, out_hi, pwm_lo, pwm_hi, duty} !== 40'h0 || pending !== 1'b0 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL rstpend_clear regs=%h pending=%b err=%b exp=0/0/0",
                     {out_lo, out_hi, pwm_lo, pwm_hi, duty}, pending, addr_err);
        end
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (commit_pulse !== 1'b0 || duty !== 8'h00) begin
                failures++;
                $display("FAIL rstpend_no_commit cyc=%0d pulse=%b duty=%h exp=0/00", i, commit_pulse, duty);
            end
        end
    endtask

    task automatic test_timeout();
        rst_b = 1'b0;
        wr_valid_b = 1'b1;
        wr_addr_b  = 7'h04;
        wr_data_b  = 8'h40;
        $display("txn write_b addr=0x04 data=0x40 t=%0t", $time);
        tick();
        wr_valid_b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (duty_b !== ((i >= 9) ? 8'h40 : 8'h00) || commit_pulse_b !== (i == 9)) begin
                failures++;
                $display("FAIL timeout cyc=%0d duty=%h pulse=%b exp=%h/%b", i, duty_b, commit_pulse_b,
                         (i >= 9) ? 8'h40 : 8'h00, (i == 9));
            end
        end
    endtask

    task automatic test_random();
        logic [43:0] got, exp;
        for (int n = 0; n < 400; n++) begin
            // Hold address/data while a write is stalled by the commit cycle.
            if (!(wr_valid && m_trig >= 0)) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_addr  = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(5, 127))
                                                       : 7'($urandom_range(0, 4));
                wr_data  = 8'($urandom);
            end
            period_end   = ($urandom_range(0, 9) == 0);
            force_commit = ($urandom_range(0, 29) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            if (wr_valid && m_trig < 0)
                $display("txn rand addr=0x%02h data=0x%02h pe=%b fc=%b rst=%b",
                         wr_addr, wr_data, period_end, force_commit, rst);
            tick();
            got = {out_lo, out_hi, pwm_lo, pwm_hi, duty, pending, commit_pulse, addr_err, wr_ready};
            exp = {m_act[0], m_act[1], m_act[2], m_act[3], m_act[4], m_pend, m_pulse, m_err, (m_trig < 0)};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random n=%0d got=%h exp=%h", n, got, exp);
            end
        end
        wr_valid = 1'b0;
        period_end = 1'b0;
        force_commit = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_period_commit();
        test_back_to_back();
        test_addr_err();
        test_reset_pending();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_cfg_scheduler.md
Name: pwm_cfg_scheduler

Overview:
- Sits between the SPI register-write path and the PWM peripheral. It owns the five PWM configuration registers: addresses 0x00–0x04, which are output enable [7:0], output enable [15:8], PWM enable [7:0], PWM enable [15:8] and duty cycle.
- Output-enable writes take effect at once.
- PWM-enable and duty writes are held in shadow registers. They are committed together at a PWM period boundary, so waveforms never glitch mid-period.
- A timeout forces the commit if no boundary ever arrives.

Parameters:
- ADDR_W, 7, register address width.
- DATA_W, 8, register data width.
- MAX_WAIT, 4096, cycles a commit may stay pending before it is forced. Legal range is ≥ 2.
- CNT_W, $clog2(MAX_WAIT), width of the wait counter.

Ports:
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- wr_valid  in  1  write request from the SPI peripheral.
- wr_ready  out  1  scheduler can accept a write this cycle.
- wr_addr  in  ADDR_W  register address.
- wr_data  in  DATA_W  register data.
- period_end  in  1  single-cycle pulse on the PWM counter wrap.
- force_commit  in  1  commit pending shadow values now.
- en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  out  DATA_W each  active registers driving the PWM peripheral.
- pending  out  1  shadow holds uncommitted deferred data.
- commit_pulse  out  1  one-cycle pulse after each commit.
- addr_err  out  1  sticky flag: a write to an address > 0x04 was accepted.

Behaviour:
- Reset (rst high at an edge):
  - All active and shadow registers go to 0x00.
  - pending=0, commit_pulse=0, addr_err=0, wait counter=0, state=IDLE.
  - Reset mid-PENDING discards shadow contents; no commit occurs.
- Write handshake: a write is accepted at an edge where wr_valid && wr_ready. wr_ready = (state != COMMIT). wr_addr and wr_data must stay stable while wr_valid is high and wr_ready is low.
- Immediate class (0x00, 0x01): the active register updates at the accepting edge. These writes never affect pending.
- Deferred class (0x02–0x04): the shadow register updates at the accepting edge, and state goes IDLE→PENDING if it was IDLE. A repeat write in PENDING overwrites the shadow and does not restart the wait counter.
- Invalid address (> 0x04): the write is accepted and its data dropped. addr_err is set and held until reset.
- States:
  - IDLE: pending=0, wait counter held at 0.
  - PENDING: pending=1, wait counter increments each cycle. Go to COMMIT when period_end, force_commit, or wait counter == MAX_WAIT-1.
  - COMMIT: lasts exactly one cycle.
    - At its closing edge, the three active deferred registers are loaded from shadow, the wait counter clears and state returns to IDLE.
    - commit_pulse is high the cycle after that edge.
    - pending stays 1 throughout COMMIT and drops at the same edge.
- Simultaneous events:
  - Deferred write and transition trigger at the same edge: the write lands in shadow and is included in the commit.
  - period_end or force_commit in IDLE: ignored.
  - period_end and force_commit together: a single commit.
- Latency:
  - Immediate write: 0 cycles after acceptance.
  - Deferred write: at least 2 edges after the trigger edge is seen. Worst case is MAX_WAIT+1 cycles after entering PENDING.
- Outputs are registered. There are no combinational paths from inputs to outputs except wr_ready, which decodes state only.

Decomposition:
- Shared package pwm_cfg_pkg holds:
  - register address localparams: ADDR_OUT_LO=0x00, ADDR_OUT_HI=0x01, ADDR_PWM_LO=0x02, ADDR_PWM_HI=0x03, ADDR_DUTY=0x04, ADDR_MAX=0x04;
  - the state enum (IDLE, PENDING, COMMIT).
- The SPI peripheral imports the same address constants.
- One sub-module, pwm_cfg_shadow_bank, holds the three shadow registers and the three deferred active registers, with write-enable and commit strobes. The FSM, wait counter and immediate registers stay in the top level.

Test Plan:
- Reset, then write 0x00←0xA5 → en_reg_out_7_0=0xA5 the cycle after acceptance; pending stays 0; commit_pulse never fires.
- Write 0x04←0x80, then pulse period_end 10 cycles later → pwm_duty_cycle stays 0x00 until 2 edges after the pulse, then reads 0x80. commit_pulse is high for exactly 1 cycle, and wr_ready is low for exactly 1 cycle.
- Write 0x02←0x0F and 0x03←0xF0 in PENDING, with period_end asserted on the 0x03 accept edge → both registers commit together at the following edge.
- With MAX_WAIT=8, write 0x04←0x40 and never pulse period_end → the commit is forced. pwm_duty_cycle=0x40 exactly 9 cycles after acceptance.
- Write 0x05←0xFF → accepted, every register unchanged, addr_err=1 and stays 1 across later valid writes until rst.
- Assert rst during PENDING after 0x04←0x33 → all outputs 0x00, pending=0, and no commit_pulse follows even when period_end arrives afterwards.
